// File: rtl/dense_layer_ctrl.sv
// rtl/dense_layer_ctrl.sv - fully-connected layer sequencer driving one shared neuron via start/done.
// Define DENSE_RELU_EN to clamp negative neuron results to zero before they are emitted.
module dense_layer_ctrl #(
  parameter  int SIZE    = 2,
  parameter  int WIDTH   = 8,
  parameter  int NEURONS = 4,
  localparam int AW      = $clog2(NEURONS*SIZE) + 1,
  localparam int JW      = $clog2(NEURONS) + 1,
  localparam int KW      = $clog2(SIZE) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    layer_start,
  input  logic [WIDTH*SIZE-1:0]   inputs_in,
  output logic                    wmem_rd,
  output logic [AW-1:0]           wmem_addr,
  input  logic [WIDTH-1:0]        wmem_data,
  output logic                    n_start,
  output logic [WIDTH*SIZE-1:0]   n_weights,
  output logic [WIDTH*SIZE-1:0]   n_inputs,
  input  logic [2*WIDTH:0]        n_result,
  input  logic                    n_done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WIDTH:0]        out_data,
  output logic [JW-1:0]           out_index,
  output logic                    busy,
  output logic                    layer_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [JW-1:0]         j_q, j_d;
  logic [KW-1:0]         k_q, k_d;
  logic [AW-1:0]         addr_q;
  logic                  rdv_q;
  logic [KW-1:0]         rdi_q;
  logic [WIDTH*SIZE-1:0] wts_q;
  logic [WIDTH*SIZE-1:0] inp_q;
  logic [2*WIDTH:0]      odata_q, odata_d;
  logic [JW-1:0]         oidx_q, oidx_d;
  logic                  ovalid_q, ovalid_d;
  logic                  rd;
  logic [AW-1:0]         cur_addr;
  logic [2*WIDTH:0]      result_v;

  assign rd       = (state_q == LOAD) && (k_q < KW'(SIZE));
  assign cur_addr = AW'(j_q) * AW'(SIZE) + AW'(k_q);

  // Address is live during a read and parked on the last issued value otherwise.
  assign wmem_rd    = rd;
  assign wmem_addr  = rd ? cur_addr : addr_q;
  assign n_start    = (state_q == START);
  assign n_weights  = wts_q;
  assign n_inputs   = inp_q;
  assign out_valid  = ovalid_q;
  assign out_data   = odata_q;
  assign out_index  = oidx_q;
  assign busy       = (state_q != IDLE);
  assign layer_done = (state_q == DONE);

`ifdef DENSE_RELU_EN
  assign result_v = n_result[2*WIDTH] ? '0 : n_result;
`else
  assign result_v = n_result;
`endif

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    k_d      = k_q;
    odata_d  = odata_q;
    oidx_d   = oidx_q;
    ovalid_d = ovalid_q;
    case (state_q)
      IDLE: begin
        if (layer_start) begin
          state_d = LOAD;
          j_d     = '0;
          k_d     = '0;
        end
      end
      LOAD: begin
        // The extra cycle at k==SIZE lets the final read data land in the weight register.
        if (k_q < KW'(SIZE)) k_d = k_q + KW'(1);
        else                 state_d = START;
      end
      START: state_d = WAIT;
      WAIT: begin
        if (n_done) begin
          odata_d  = result_v;
          oidx_d   = j_q;
          ovalid_d = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          ovalid_d = 1'b0;
          if (j_q == JW'(NEURONS-1)) begin
            state_d = DONE;
          end else begin
            j_d     = j_q + JW'(1);
            k_d     = '0;
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        j_d     = '0;
        k_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      j_q      <= '0;
      k_q      <= '0;
      addr_q   <= '0;
      rdv_q    <= 1'b0;
      rdi_q    <= '0;
      wts_q    <= '0;
      inp_q    <= '0;
      odata_q  <= '0;
      oidx_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      k_q      <= k_d;
      odata_q  <= odata_d;
      oidx_q   <= oidx_d;
      ovalid_q <= ovalid_d;
      rdv_q    <= rd;
      rdi_q    <= k_q;
      if (rd) addr_q <= cur_addr;
      if (state_q == IDLE && layer_start) inp_q <= inputs_in;
      if (rdv_q) begin
        for (int e = 0; e < SIZE; e++) begin
          if (rdi_q == KW'(e)) wts_q[e*WIDTH +: WIDTH] <= wmem_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// tb/tb_dense_layer_ctrl.sv - directed bench for dense_layer_ctrl with a behavioural neuron and weight memory.
// Expected second output follows DENSE_RELU_EN.
module tb_dense_layer_ctrl;

  localparam int SIZE = 2;
  localparam int WIDTH = 8;
  localparam int NEURONS = 2;
`ifdef DENSE_RELU_EN
  localparam int EXP1 = 0;
`else
  localparam int EXP1 = -22;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        layer_start = 1'b0;
  logic [15:0] inputs_in = 16'hFE03;
  logic        wmem_rd;
  logic [2:0]  wmem_addr;
  logic [7:0]  wmem_data;
  logic        n_start;
  logic [15:0] n_weights;
  logic [15:0] n_inputs;
  logic [16:0] n_result;
  logic        n_done;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [16:0] out_data;
  logic [1:0]  out_index;
  logic        busy;
  logic        layer_done;

  dense_layer_ctrl #(.SIZE(SIZE), .WIDTH(WIDTH), .NEURONS(NEURONS)) dut (
    .clk(clk), .reset(reset), .layer_start(layer_start), .inputs_in(inputs_in),
    .wmem_rd(wmem_rd), .wmem_addr(wmem_addr), .wmem_data(wmem_data),
    .n_start(n_start), .n_weights(n_weights), .n_inputs(n_inputs),
    .n_result(n_result), .n_done(n_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .busy(busy), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [4];
  initial begin
    mem[0] = 8'd4; mem[1] = 8'd1; mem[2] = 8'hFC; mem[3] = 8'd5;
  end

  always @(posedge clk) if (wmem_rd) wmem_data <= mem[wmem_addr];

  function automatic logic [16:0] dot(input logic [15:0] w, input logic [15:0] x);
    logic signed [16:0] s;
    s = '0;
    for (int e = 0; e < SIZE; e++)
      s = s + 17'($signed(w[8*e +: 8])) * 17'($signed(x[8*e +: 8]));
    return s;
  endfunction

  // Neuron: captures operands on start, raises done SIZE+1 cycles later.
  int ncnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n_done <= 1'b0; ncnt <= 0; n_result <= '0;
    end else if (n_start) begin
      n_done <= 1'b0; ncnt <= SIZE + 1; n_result <= dot(n_weights, n_inputs);
    end else if (ncnt != 0) begin
      ncnt <= ncnt - 1;
      if (ncnt == 1) n_done <= 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;
  int acc_n, ld_cnt, st_cnt, addr_n, dbl_start;
  logic [16:0] acc_d [8];
  logic [1:0]  acc_i [8];
  logic [2:0]  addr_s [8];
  logic        prev_start = 1'b0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (acc_n < 8) begin acc_d[acc_n] = out_data; acc_i[acc_n] = out_index; end
      acc_n++;
    end
    if (layer_done) ld_cnt++;
    if (n_start) begin st_cnt++; if (prev_start) dbl_start++; end
    prev_start = n_start;
    if (wmem_rd) begin
      if (addr_n < 8) addr_s[addr_n] = wmem_addr;
      addr_n++;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    acc_n = 0; ld_cnt = 0; st_cnt = 0; addr_n = 0; dbl_start = 0;
  endtask

  task automatic pulse_start();
    layer_start = 1'b1; step(); layer_start = 1'b0;
  endtask

  task automatic wait_layer(input string tag);
    int t;
    t = 0;
    while (ld_cnt < 1 && t < 300) begin step(); t++; end
    step();
    chk(tag, ld_cnt, 1);
  endtask

  task automatic wait_nstart(input string tag);
    int t;
    t = 0;
    while (!n_start && t < 100) begin step(); t++; end
    chk(tag, 32'(n_start), 1);
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_count"}, acc_n, 2);
    chk({tag, "_d0"}, 32'($signed(acc_d[0])), 10);
    chk({tag, "_i0"}, 32'(acc_i[0]), 0);
    chk({tag, "_d1"}, 32'($signed(acc_d[1])), EXP1);
    chk({tag, "_i1"}, 32'(acc_i[1]), 1);
    chk({tag, "_nstart"}, st_cnt, 2);
    chk({tag, "_dblstart"}, dbl_start, 0);
    chk({tag, "_busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    clr();
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_rd", 32'(wmem_rd), 0);
    chk("rst_nstart", 32'(n_start), 0);
    chk("rst_done", 32'(layer_done), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_addr", 32'(wmem_addr), 0);
    step(); step();
    reset = 1'b0;
    step();

    // basic pass with addresses
    clr();
    pulse_start();
    wait_layer("t1_done");
    chk_results("t1");
    chk("t1_addr_n", addr_n, 4);
    for (int a = 0; a < 4; a++) chk($sformatf("t1_addr%0d", a), 32'(addr_s[a]), a);

    // backpressure on index 0
    clr();
    out_ready = 1'b0;
    pulse_start();
    begin
      int t;
      t = 0;
      while (!out_valid && t < 100) begin step(); t++; end
    end
    for (int c = 0; c < 5; c++) begin
      chk("t3_valid", 32'(out_valid), 1);
      chk("t3_data", 32'($signed(out_data)), 10);
      chk("t3_index", 32'(out_index), 0);
      chk("t3_no_rd", 32'(wmem_rd), 0);
      step();
    end
    chk("t3_addr_held", addr_n, 2);
    chk("t3_weights", 32'(n_weights), 32'h0104);
    chk("t3_inputs", 32'(n_inputs), 32'hFE03);
    out_ready = 1'b1;
    wait_layer("t3_done");
    chk_results("t3");

    // layer_start re-pulsed during WAIT
    clr();
    pulse_start();
    wait_nstart("t4_nstart_seen");
    step();
    pulse_start();
    wait_layer("t4_done");
    repeat (10) step();
    chk_results("t4");
    chk("t4_single_done", ld_cnt, 1);

    // asynchronous reset during WAIT of index 0
    clr();
    pulse_start();
    wait_nstart("t5_nstart_seen");
    step();
    reset = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_data", 32'(out_data), 0);
    chk("t5_weights", 32'(n_weights), 0);
    chk("t5_inputs", 32'(n_inputs), 0);
    step(); step();
    reset = 1'b0;
    repeat (10) step();
    chk("t5_no_output", acc_n, 0);
    chk("t5_no_done", ld_cnt, 0);
    clr();
    pulse_start();
    wait_layer("t5_done");
    chk_results("t5");

    // inputs change after capture
    clr();
    pulse_start();
    inputs_in = 16'h7F7F;
    wait_layer("t6_done");
    chk_results("t6");
    chk("t6_inputs_held", 32'(n_inputs), 32'hFE03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
